fifo_uart_tx: RTL

Serial transmit engine that drains the team's 8-bit synchronous FIFO from its read side and sends each byte as an asynchronous UART frame (start, 8 data bits LSB first, optional parity, stop). The block drives the FIFO's read enable, samples the FIFO's registered data output, and owns the serial `tx` line. It sits between the byte FIFO and the chip's TX pad.

---
 rtl/fifo_uart_tx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter draining a byte FIFO (start, 8 data LSB first, stop).
// Optional even-parity bit compiled in with FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          rd_en_q, rd_en_d;
    logic          tx_done_q, tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic baud_last;
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        rd_en_d   = 1'b0;
        tx_done_d = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                stop_d = 1'b0;
                if (enable && !fifo_empty) begin
                    state_d = POP;
                    rd_en_d = 1'b1;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            // FIFO read data is registered, so it is only valid here, one cycle after the pop.
            LOAD: begin
                shift_d  = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
                tx_d     = 1'b0;
                baud_d   = '0;
                state_d  = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                // Registered pulse: raise it one cycle ahead so it lands on the final stop cycle.
                tx_done_d = (baud_q == BAUD_PRE) && (stop_q == STOP_LAST);
                if (baud_last) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            tx_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            tx_done_q <= tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign tx_done    = tx_done_q;
    assign busy       = (state_q != IDLE);

endmodule
